// File: rtl/img_stream_pkg.sv
// Shared constants and types for the frame-granular image stream arbiter.
package img_stream_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // A zero-line frame makes no sense, so the arbiter treats it as one line.
  function automatic logic [CNT_W-1:0] height_or_one(input logic [CNT_W-1:0] h);
    return (h == '0) ? CNT_W'(1) : h;
  endfunction
endpackage

// File: rtl/stream_rr_pick2.sv
// Two-way round-robin pick: ptr decides only when both sources request.
module stream_rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_idx,
  output logic       gnt_vld
);
  always_comb begin
    gnt_vld = |req;
    gnt_idx = (&req) ? ptr : req[1];
  end
endmodule

// File: rtl/img_frame_arb.sv
// Two-source image stream arbiter: grants whole frames (SOF to last line)
// to one source at a time and drains stray non-SOF beats while idle.
module img_frame_arb
  import img_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  IMG_HEIGHT,
  input  logic              arb_en,
  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tuser,
  input  logic              s0_axis_tlast,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tuser,
  input  logic              s1_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              active_src,
  output logic [CNT_W-1:0]  frame_cnt0,
  output logic [CNT_W-1:0]  frame_cnt1,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              err_sof,
  input  logic              err_clr
);
  arb_state_e state, state_nxt;

  logic [1:0]             vld, usr, lst, req, drop;
  logic [1:0][DATA_W-1:0] dat;
  logic                   ptr, first_beat;
  logic [CNT_W-1:0]       line_cnt, h_lat, eff_line;
  logic                   pick_idx, pick_vld, grant_go;
  logic                   hs, sof_err, frame_end;
  logic [CNT_W:0]         drop_sum;

  assign vld  = {s1_axis_tvalid, s0_axis_tvalid};
  assign usr  = {s1_axis_tuser,  s0_axis_tuser};
  assign lst  = {s1_axis_tlast,  s0_axis_tlast};
  assign dat  = {s1_axis_tdata,  s0_axis_tdata};
  assign req  = vld & usr;
  assign drop = vld & ~usr;

  stream_rr_pick2 u_pick (
    .req     (req),
    .ptr     (ptr),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  assign grant_go  = (state == IDLE) && arb_en && pick_vld;
  assign hs        = (state == GRANT) && m_axis_tvalid && m_axis_tready;
  // A late SOF starts the frame over: that beat belongs to line 0.
  assign sof_err   = hs && m_axis_tuser && !first_beat;
  assign eff_line  = sof_err ? '0 : line_cnt;
  assign frame_end = hs && m_axis_tlast && (eff_line == CNT_W'(h_lat - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_go)  state_nxt = GRANT;
      GRANT:   if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset forces every handshake output low even though the paths are combinational.
  always_comb begin
    busy           = (state == GRANT);
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tuser   = 1'b0;
    m_axis_tlast   = 1'b0;
    if (!rst) begin
      if (state == GRANT) begin
        m_axis_tvalid = vld[active_src];
        m_axis_tdata  = dat[active_src];
        m_axis_tuser  = usr[active_src];
        m_axis_tlast  = lst[active_src];
        if (active_src) s1_axis_tready = m_axis_tready;
        else            s0_axis_tready = m_axis_tready;
      end else begin
        s0_axis_tready = drop[0];
        s1_axis_tready = drop[1];
      end
    end
  end

  assign drop_sum = {1'b0, drop_cnt}
                  + (CNT_W+1)'(drop[0] && state == IDLE)
                  + (CNT_W+1)'(drop[1] && state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= 1'b0;
      active_src <= 1'b0;
      first_beat <= 1'b0;
      line_cnt   <= '0;
      h_lat      <= CNT_W'(1);
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
      drop_cnt   <= '0;
      err_sof    <= 1'b0;
    end else begin
      if (grant_go) begin
        active_src <= pick_idx;
        h_lat      <= height_or_one(IMG_HEIGHT);
        line_cnt   <= '0;
        first_beat <= 1'b1;
      end else if (hs) begin
        first_beat <= 1'b0;
        line_cnt   <= m_axis_tlast ? CNT_W'(eff_line + CNT_W'(1)) : eff_line;
        if (frame_end) begin
          ptr <= ~active_src;
          if (active_src) frame_cnt1 <= frame_cnt1 + CNT_W'(1);
          else            frame_cnt0 <= frame_cnt0 + CNT_W'(1);
        end
      end
      drop_cnt <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
      if (sof_err)      err_sof <= 1'b1;
      else if (err_clr) err_sof <= 1'b0;
    end
  end
endmodule

// File: tb/tb_img_frame_arb.sv
// Directed bench for img_frame_arb: frame forwarding, arbitration, draining,
// backpressure, late-SOF recovery and mid-frame reset.
module tb_img_frame_arb;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0]   img_h = 16'd4;
  logic          arb_en = 1'b1, err_clr = 1'b0, m_rdy = 1'b1;
  logic          sv[2], su[2], sl[2];
  logic [DW-1:0] sd[2];
  logic          s0_rdy, s1_rdy, m_vld, m_usr, m_lst, busy, act, err_sof;
  logic [DW-1:0] m_dat;
  logic [15:0]   fc0, fc1, dc;

  int checks = 0, errors = 0, cyc = 0;
  logic [DW+1:0] mon_q[$];
  int            mon_cyc[$];
  bit            chk_s1 = 0, s1_seen = 0, bp_done = 0;

  img_frame_arb #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .IMG_HEIGHT(img_h), .arb_en(arb_en),
    .s0_axis_tvalid(sv[0]), .s0_axis_tready(s0_rdy), .s0_axis_tdata(sd[0]),
    .s0_axis_tuser(su[0]), .s0_axis_tlast(sl[0]),
    .s1_axis_tvalid(sv[1]), .s1_axis_tready(s1_rdy), .s1_axis_tdata(sd[1]),
    .s1_axis_tuser(su[1]), .s1_axis_tlast(sl[1]),
    .m_axis_tvalid(m_vld), .m_axis_tready(m_rdy), .m_axis_tdata(m_dat),
    .m_axis_tuser(m_usr), .m_axis_tlast(m_lst),
    .busy(busy), .active_src(act), .frame_cnt0(fc0), .frame_cnt1(fc1),
    .drop_cnt(dc), .err_sof(err_sof), .err_clr(err_clr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && m_vld && m_rdy) begin
      mon_q.push_back({m_dat, m_usr, m_lst});
      mon_cyc.push_back(cyc);
    end
    if (chk_s1 && busy && s1_rdy) s1_seen = 1;
  end

  // Beat i of a frame of width w; rs >= 0 places a fresh SOF there and restarts lines.
  function automatic logic [DW+1:0] beat(input int i, input int w, input int rs, input int base);
    int k;
    logic u, l;
    k = (rs >= 0 && i >= rs) ? i - rs : i;
    u = (i == 0) || (i == rs);
    l = ((k + 1) % w) == 0;
    return {DW'(base + i), u, l};
  endfunction

  task automatic drive_frame(input int src, input int n, input int w, input int rs, input int base);
    logic [DW+1:0] b;
    bit hs;
    int wc;
    for (int i = 0; i < n; i++) begin
      b = beat(i, w, rs, base);
      sv[src] = 1'b1; sd[src] = b[DW+1:2]; su[src] = b[1]; sl[src] = b[0];
      wc = 0;
      do begin
        @(negedge clk);
        hs = (src == 0) ? s0_rdy : s1_rdy;
        @(posedge clk); #1;
        wc++;
      end while (!hs && wc < 500);
      if (!hs) begin
        checks++; errors++;
        $display("FAIL drive_timeout: src%0d beat %0d got no tready, required within 500 cycles", src, i);
        break;
      end
    end
    sv[src] = 1'b0; su[src] = 1'b0; sl[src] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; arb_en = 1'b1; err_clr = 1'b0; m_rdy = 1'b1; img_h = 16'd4;
    for (int s = 0; s < 2; s++) begin sv[s] = 0; su[s] = 0; sl[s] = 0; sd[s] = '0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_q.delete(); mon_cyc.delete();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    sv[0] = 1; su[0] = 1; sv[1] = 1; su[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (s0_rdy !== 1'b0 || s1_rdy !== 1'b0) begin errors++;
      $display("FAIL reset_tready: got %b%b required 00", s1_rdy, s0_rdy); end
    checks++; if (busy !== 1'b0 || m_vld !== 1'b0) begin errors++;
      $display("FAIL reset_busy_mvalid: got %b%b required 00", busy, m_vld); end
    checks++; if (fc0 !== 16'd0 || fc1 !== 16'd0 || dc !== 16'd0) begin errors++;
      $display("FAIL reset_counters: got %0h %0h %0h required 0 0 0", fc0, fc1, dc); end
    checks++; if (err_sof !== 1'b0 || act !== 1'b0) begin errors++;
      $display("FAIL reset_err_act: got %b %b required 0 0", err_sof, act); end
    do_reset();
  endtask

  task automatic test_single_frame();
    int c0;
    do_reset();
    c0 = cyc;
    drive_frame(0, 32, 8, -1, 'h100);
    @(negedge clk);
    checks++; if (mon_q.size() !== 32) begin errors++;
      $display("FAIL single_count: got %0d beats required 32", mon_q.size()); end
    for (int i = 0; i < mon_q.size() && i < 32; i++) begin
      checks++; if (mon_q[i] !== beat(i, 8, -1, 'h100)) begin errors++;
        $display("FAIL single_beat%0d: got %0h required %0h", i, mon_q[i], beat(i, 8, -1, 'h100)); end
    end
    checks++; if (mon_cyc.size() > 0 && mon_cyc[0] !== c0 + 1) begin errors++;
      $display("FAIL single_grant_latency: got cycle %0d required %0d", mon_cyc[0], c0 + 1); end
    checks++; if (busy !== 1'b0 || fc0 !== 16'd1 || fc1 !== 16'd0) begin errors++;
      $display("FAIL single_end: got busy %b fc0 %0d fc1 %0d required 0 1 0", busy, fc0, fc1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    img_h = 16'd2;
    fork
      drive_frame(0, 8, 4, -1, 'h200);
      drive_frame(1, 8, 4, -1, 'h300);
    join
    @(negedge clk);
    checks++; if (mon_q.size() !== 16) begin errors++;
      $display("FAIL b2b_count: got %0d beats required 16", mon_q.size()); end
    for (int i = 0; i < mon_q.size() && i < 16; i++) begin
      checks++;
      if (mon_q[i] !== (i < 8 ? beat(i, 4, -1, 'h200) : beat(i - 8, 4, -1, 'h300))) begin errors++;
        $display("FAIL b2b_beat%0d: got %0h required %0h", i, mon_q[i],
                 (i < 8 ? beat(i, 4, -1, 'h200) : beat(i - 8, 4, -1, 'h300))); end
    end
    checks++; if (mon_cyc.size() >= 9 && (mon_cyc[8] - mon_cyc[7]) !== 2) begin errors++;
      $display("FAIL b2b_gap: got %0d cycles required 2", mon_cyc[8] - mon_cyc[7]); end
    checks++; if (fc0 !== 16'd1 || fc1 !== 16'd1 || busy !== 1'b0) begin errors++;
      $display("FAIL b2b_counts: got fc0 %0d fc1 %0d busy %b required 1 1 0", fc0, fc1, busy); end
  endtask

  task automatic test_drop();
    do_reset();
    sv[1] = 1; su[1] = 0;
    for (int i = 0; i < 5; i++) begin
      sd[1] = DW'(i);
      @(negedge clk);
      checks++; if (s1_rdy !== 1'b1 || m_vld !== 1'b0) begin errors++;
        $display("FAIL drop_cycle%0d: got tready %b m_valid %b required 1 0", i, s1_rdy, m_vld); end
      @(posedge clk); #1;
    end
    sv[1] = 0;
    @(negedge clk);
    checks++; if (dc !== 16'd5) begin errors++;
      $display("FAIL drop_cnt5: got %0d required 5", dc); end
    @(posedge clk); #1;
    sv[0] = 1; su[0] = 0; sv[1] = 1;
    repeat (3) @(posedge clk);
    #1 sv[0] = 0; sv[1] = 0;
    @(negedge clk);
    checks++; if (dc !== 16'd11) begin errors++;
      $display("FAIL drop_dual: got %0d required 11", dc); end
    @(posedge clk); #1;
    sv[0] = 1; sv[1] = 1;
    repeat (32768) @(posedge clk);
    #1 sv[0] = 0; sv[1] = 0;
    @(negedge clk);
    checks++; if (dc !== 16'hFFFF) begin errors++;
      $display("FAIL drop_saturate: got %0h required ffff", dc); end
  endtask

  task automatic test_arb_en_h0();
    do_reset();
    arb_en = 1'b0; img_h = 16'd0;
    fork
      drive_frame(0, 4, 4, -1, 'h500);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checks++; if (busy !== 1'b0 || s0_rdy !== 1'b0) begin errors++;
            $display("FAIL arb_hold%0d: got busy %b tready %b required 0 0", i, busy, s0_rdy); end
          @(posedge clk);
        end
        #1 arb_en = 1'b1;
      end
    join
    @(negedge clk);
    checks++; if (mon_q.size() !== 4 || busy !== 1'b0 || fc0 !== 16'd1) begin errors++;
      $display("FAIL h0_one_line: got beats %0d busy %b fc0 %0d required 4 0 1", mon_q.size(), busy, fc0); end
  endtask

  task automatic test_backpressure();
    do_reset();
    img_h = 16'd2;
    chk_s1 = 1; s1_seen = 0; bp_done = 0;
    sv[1] = 1; su[1] = 0;
    fork
      begin drive_frame(0, 8, 4, -1, 'h600); bp_done = 1; end
      while (!bp_done) begin
        m_rdy = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    join
    m_rdy = 1'b1; sv[1] = 0; chk_s1 = 0;
    @(negedge clk);
    checks++; if (mon_q.size() !== 8) begin errors++;
      $display("FAIL bp_count: got %0d beats required 8", mon_q.size()); end
    for (int i = 0; i < mon_q.size() && i < 8; i++) begin
      checks++; if (mon_q[i] !== beat(i, 4, -1, 'h600)) begin errors++;
        $display("FAIL bp_beat%0d: got %0h required %0h", i, mon_q[i], beat(i, 4, -1, 'h600)); end
    end
    checks++; if (s1_seen !== 1'b0) begin errors++;
      $display("FAIL bp_s1_tready: got %b required 0", s1_seen); end
  endtask

  task automatic test_sof_err();
    do_reset();
    drive_frame(0, 42, 8, 10, 'h700);
    @(negedge clk);
    checks++; if (mon_q.size() !== 42 || busy !== 1'b0 || fc0 !== 16'd1) begin errors++;
      $display("FAIL sof_frame: got beats %0d busy %b fc0 %0d required 42 0 1", mon_q.size(), busy, fc0); end
    checks++; if (err_sof !== 1'b1) begin errors++;
      $display("FAIL sof_set: got %b required 1", err_sof); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (err_sof !== 1'b1) begin errors++;
      $display("FAIL sof_sticky: got %b required 1", err_sof); end
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    checks++; if (err_sof !== 1'b0) begin errors++;
      $display("FAIL sof_clear: got %b required 0", err_sof); end
  endtask

  task automatic test_reset_mid();
    logic [DW+1:0] b;
    do_reset();
    drive_frame(0, 9, 4, -1, 'h800);
    b = beat(9, 4, -1, 'h800);
    sv[0] = 1; sd[0] = b[DW+1:2]; su[0] = b[1]; sl[0] = b[0];
    rst = 1'b1;
    @(negedge clk);
    checks++; if (s0_rdy !== 1'b0 || m_vld !== 1'b0) begin errors++;
      $display("FAIL rmid_during: got tready %b m_valid %b required 0 0", s0_rdy, m_vld); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || fc0 !== 16'd0) begin errors++;
      $display("FAIL rmid_after: got busy %b fc0 %0d required 0 0", busy, fc0); end
    checks++; if (s0_rdy !== 1'b0 || s1_rdy !== 1'b0) begin errors++;
      $display("FAIL rmid_tready: got %b%b required 00", s1_rdy, s0_rdy); end
    do_reset();
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin sv[s] = 0; su[s] = 0; sl[s] = 0; sd[s] = '0; end
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_drop();
    test_arb_en_h0();
    test_backpressure();
    test_sof_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
